// File: rtl/seq_divider_param_if.sv
// Divider operand/result bundle between a controller (master) and the divider (slave).
// Latency: none, wires only.
// Backpressure: the controller holds off new requests while busy; requests made while busy are dropped.
interface seq_divider_param_if #(
   parameter int N = 4
);
   logic             st;
   logic             sgn;
   logic [2*N-1:0]   dividend;
   logic [N-1:0]     divisor;
   logic [N-1:0]     quot;
   logic [N-1:0]     rem;
   logic             busy;
   logic             done;
   logic             v;
   logic             dz;

   modport master (
      output st, sgn, dividend, divisor,
      input  quot, rem, busy, done, v, dz
   );

   modport slave (
      input  st, sgn, dividend, divisor,
      output quot, rem, busy, done, v, dz
   );
endinterface

// File: rtl/seq_divider_param.sv
// Restoring sequential divider: 2N-bit dividend / N-bit divisor, unsigned or two's-complement.
// Latency: done 2 clocks after an accepted st on overflow/divide-by-zero, N+2 clocks otherwise.
// Backpressure: st is accepted only when idle (including the done cycle); st while busy is dropped.
module seq_divider_param #(
   parameter int N = 4
) (
   input  logic               clk,
   input  logic               rst,
   seq_divider_param_if.slave bus
);

   localparam int CW = $clog2(N + 1);

   // Largest positive and largest negative magnitude a signed N-bit quotient can hold.
   localparam logic [N-1:0] QMAX_POS = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] QMAX_NEG = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      SHIFT = 2'd2,
      FIX   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    dmag_q,  dmag_d;    // |divisor|
   logic [N-1:0]    pr_q,    pr_d;      // partial remainder (upper half of |dividend| at start)
   logic [N-1:0]    lo_q,    lo_d;      // low half of |dividend|, becomes the quotient magnitude
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic            sgn_q,   sgn_d;
   logic            qneg_q,  qneg_d;
   logic            rneg_q,  rneg_d;
   logic            err_q,   err_d;     // early overflow found in CHECK
   logic            zero_q,  zero_d;    // early overflow was a divide-by-zero
   logic [N-1:0]    quot_q,  quot_d;
   logic [N-1:0]    rem_q,   rem_d;
   logic            busy_q,  busy_d;
   logic            done_q,  done_d;
   logic            v_q,     v_d;
   logic            dz_q,    dz_d;

   logic [2*N-1:0]  dd_mag;
   logic [N-1:0]    dv_mag;
   logic [N:0]      trial;

   // Operand magnitudes formed straight from the request so they can be latched with st.
   always_comb begin
      dd_mag = bus.dividend;
      dv_mag = bus.divisor;
      if (bus.sgn && bus.dividend[2*N-1]) begin
         dd_mag = -bus.dividend;
      end
      if (bus.sgn && bus.divisor[N-1]) begin
         dv_mag = -bus.divisor;
      end
   end

   // Next-state and datapath: latch, early range check, N shift/subtract steps, sign fix-up.
   always_comb begin
      state_d = state_q;
      dmag_d  = dmag_q;
      pr_d    = pr_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      sgn_d   = sgn_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      err_d   = err_q;
      zero_d  = zero_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      v_d     = v_q;
      dz_d    = dz_q;
      // The trial remainder is one bit wider than the stored one so the shifted-out MSB counts.
      trial   = {pr_q, lo_q[N-1]};

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (bus.st) begin
               sgn_d   = bus.sgn;
               dmag_d  = dv_mag;
               pr_d    = dd_mag[2*N-1:N];
               lo_d    = dd_mag[N-1:0];
               qneg_d  = bus.sgn & (bus.dividend[2*N-1] ^ bus.divisor[N-1]);
               rneg_d  = bus.sgn & bus.dividend[2*N-1];
               err_d   = 1'b0;
               zero_d  = 1'b0;
               state_d = CHECK;
            end
         end

         CHECK: begin
            busy_d = 1'b1;
            if (dmag_q == '0) begin
               err_d   = 1'b1;
               zero_d  = 1'b1;
               state_d = FIX;
            end else if (pr_q >= dmag_q) begin
               // Quotient magnitude would not fit in N bits.
               err_d   = 1'b1;
               state_d = FIX;
            end else begin
               cnt_d   = CW'(N);
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            busy_d = 1'b1;
            if (trial >= {1'b0, dmag_q}) begin
               pr_d = N'(trial - {1'b0, dmag_q});
               lo_d = {lo_q[N-2:0], 1'b1};
            end else begin
               pr_d = trial[N-1:0];
               lo_d = {lo_q[N-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = FIX;
            end
         end

         FIX: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
            if (err_q) begin
               v_d    = 1'b1;
               dz_d   = zero_q;
               quot_d = '0;
               rem_d  = '0;
            end else if (sgn_q && ((!qneg_q && (lo_q > QMAX_POS)) ||
                                   ( qneg_q && (lo_q > QMAX_NEG)))) begin
               // Magnitude fits N bits unsigned but not as a signed result.
               v_d    = 1'b1;
               dz_d   = 1'b0;
               quot_d = '0;
               rem_d  = '0;
            end else begin
               v_d    = 1'b0;
               dz_d   = 1'b0;
               quot_d = qneg_q ? -lo_q : lo_q;
               rem_d  = rneg_q ? -pr_q : pr_q;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         dmag_q  <= '0;
         pr_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         sgn_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         err_q   <= 1'b0;
         zero_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         v_q     <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dmag_q  <= dmag_d;
         pr_q    <= pr_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         sgn_q   <= sgn_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         err_q   <= err_d;
         zero_q  <= zero_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         v_q     <= v_d;
         dz_q    <= dz_d;
      end
   end

   assign bus.quot = quot_q;
   assign bus.rem  = rem_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.v    = v_q;
   assign bus.dz   = dz_q;

endmodule

// File: tb/tb_seq_divider_param.sv
// Bench for seq_divider_param: directed, randomized and control scenarios against an arithmetic model.
// Latency: checks done at 2 or N+2 clocks after the st edge.
// Backpressure: exercises st while busy, st in the done cycle and reset mid-operation.
module tb_seq_divider_param;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [N-1:0] prev_q;

   always #5 clk = ~clk;

   seq_divider_param_if #(.N(N)) bus_if ();

   seq_divider_param #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      logic           s;
      logic [2*N-1:0] dd;
      logic [N-1:0]   dv;
      logic [N-1:0]   q;
      logic [N-1:0]   r;
      logic           v;
      logic           z;
      int             lat;
   } vec_t;

   // Reference: truncating integer division with the divider's range rules.
   function automatic void model(input logic s, input logic [2*N-1:0] dd, input logic [N-1:0] dv,
                                 output logic [N-1:0] q, output logic [N-1:0] r,
                                 output logic ov, output logic z, output int lat);
      longint a, b, ma, mb, qa, ra;
      q = '0; r = '0; ov = 1'b0; z = 1'b0; lat = 2;
      if (s) begin
         a = longint'($signed(dd));
         b = longint'($signed(dv));
      end else begin
         a = longint'(dd);
         b = longint'(dv);
      end
      ma = (a < 0) ? -a : a;
      mb = (b < 0) ? -b : b;
      if (mb == 0) begin
         ov = 1'b1;
         z  = 1'b1;
      end else if ((ma >> N) >= mb) begin
         ov = 1'b1;
      end else begin
         lat = N + 2;
         qa = a / b;
         ra = a % b;
         if (s && ((qa > (longint'(1) << (N-1)) - 1) || (qa < -(longint'(1) << (N-1))))) begin
            ov = 1'b1;
         end else begin
            q = qa[N-1:0];
            r = ra[N-1:0];
         end
      end
   endfunction

   // Called with time positioned before an edge: presents a request for exactly one edge.
   task automatic start_op(input logic s, input logic [2*N-1:0] dd, input logic [N-1:0] dv);
      bus_if.st       = 1'b1;
      bus_if.sgn      = s;
      bus_if.dividend = dd;
      bus_if.divisor  = dv;
      @(posedge clk);
      #1;
      bus_if.st = 1'b0;
   endtask

   // Counts edges after the st edge until done; also counts busy cycles before it.
   task automatic wait_done(output int lat, output int bcnt, output bit to);
      int i;
      lat = 0; bcnt = 0; to = 1'b1; i = 0;
      while (to && i < 40) begin
         i++;
         @(posedge clk);
         #1;
         if (bus_if.done === 1'b1) begin
            lat = i;
            to  = 1'b0;
         end else if (bus_if.busy === 1'b1) begin
            bcnt++;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus_if.st = 1'b0; bus_if.sgn = 1'b0; bus_if.dividend = '0; bus_if.divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (bus_if.quot !== '0) begin n_bad++; $display("FAIL reset_quot: got %h exp 0", bus_if.quot); end
      n_cmp++; if (bus_if.rem  !== '0) begin n_bad++; $display("FAIL reset_rem: got %h exp 0", bus_if.rem); end
      n_cmp++; if (bus_if.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b exp 0", bus_if.busy); end
      n_cmp++; if (bus_if.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b exp 0", bus_if.done); end
      n_cmp++; if (bus_if.v    !== 1'b0) begin n_bad++; $display("FAIL reset_v: got %b exp 0", bus_if.v); end
      n_cmp++; if (bus_if.dz   !== 1'b0) begin n_bad++; $display("FAIL reset_dz: got %b exp 0", bus_if.dz); end
      @(negedge clk);
      rst = 1'b0;
      prev_q = '0;
   endtask

   task automatic test_directed;
      vec_t vecs[11];
      int   lat, bcnt;
      bit   to;
      vecs[0]  = '{1'b0, 8'h87, 4'hD, 4'hA, 4'h5, 1'b0, 1'b0, 6};  // 135/13
      vecs[1]  = '{1'b0, 8'hC8, 4'hA, 4'h0, 4'h0, 1'b1, 1'b0, 2};  // 200/10 overflow
      vecs[2]  = '{1'b0, 8'h25, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2};  // 37/0
      vecs[3]  = '{1'b0, 8'h14, 4'h3, 4'h6, 4'h2, 1'b0, 1'b0, 6};  // 20/3 clears dz
      vecs[4]  = '{1'b1, 8'hCE, 4'h7, 4'h9, 4'hF, 1'b0, 1'b0, 6};  // -50/7
      vecs[5]  = '{1'b1, 8'hC8, 4'h7, 4'h8, 4'h0, 1'b0, 1'b0, 6};  // -56/7 = -8
      vecs[6]  = '{1'b1, 8'h38, 4'h7, 4'h0, 4'h0, 1'b1, 1'b0, 6};  // 56/7 = +8 too big
      vecs[7]  = '{1'b1, 8'hC0, 4'h8, 4'h0, 4'h0, 1'b1, 1'b0, 6};  // -64/-8 = +8 too big
      vecs[8]  = '{1'b1, 8'h40, 4'h8, 4'h8, 4'h0, 1'b0, 1'b0, 6};  // 64/-8 = -8
      vecs[9]  = '{1'b0, 8'h0F, 4'hF, 4'h1, 4'h0, 1'b0, 1'b0, 6};  // 15/15
      vecs[10] = '{1'b1, 8'h01, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2};  // signed 1/0
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         start_op(vecs[k].s, vecs[k].dd, vecs[k].dv);
         wait_done(lat, bcnt, to);
         n_cmp++;
         if (to) begin
            n_bad++; $display("FAIL dir%0d_timeout: no done within 40 clocks", k);
         end else begin
            if ({bus_if.quot, bus_if.rem, bus_if.v, bus_if.dz} !== {vecs[k].q, vecs[k].r, vecs[k].v, vecs[k].z}) begin
               n_bad++;
               $display("FAIL dir%0d_result: got q=%h r=%h v=%b dz=%b exp q=%h r=%h v=%b dz=%b", k,
                        bus_if.quot, bus_if.rem, bus_if.v, bus_if.dz, vecs[k].q, vecs[k].r, vecs[k].v, vecs[k].z);
            end
            n_cmp++; if (lat != vecs[k].lat) begin n_bad++; $display("FAIL dir%0d_latency: got %0d exp %0d", k, lat, vecs[k].lat); end
            n_cmp++; if (bcnt != vecs[k].lat - 1) begin n_bad++; $display("FAIL dir%0d_busy_cycles: got %0d exp %0d", k, bcnt, vecs[k].lat - 1); end
            n_cmp++; if (bus_if.busy !== 1'b0) begin n_bad++; $display("FAIL dir%0d_busy_in_done: got %b exp 0", k, bus_if.busy); end
            @(posedge clk);
            #1;
            n_cmp++; if (bus_if.done !== 1'b0) begin n_bad++; $display("FAIL dir%0d_done_pulse: got %b exp 0", k, bus_if.done); end
         end
         prev_q = vecs[k].q;
      end
   endtask

   task automatic test_random;
      logic           s, v, z;
      logic [2*N-1:0] dd;
      logic [N-1:0]   dv, q, r, hi, lo;
      int             elat, lat, bcnt;
      bit             to;
      for (int k = 0; k < 60; k++) begin
         s  = 1'($urandom_range(0, 1));
         dv = N'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            dd = (2*N)'($urandom);
         end else if (!s) begin
            hi = (dv == '0) ? '0 : N'($urandom_range(0, int'(dv) - 1));
            lo = N'($urandom);
            dd = {hi, lo};
         end else begin
            dd = (2*N)'($urandom_range(0, 60));
            if ($urandom_range(0, 1) == 1) dd = -dd;
         end
         model(s, dd, dv, q, r, v, z, elat);
         @(negedge clk);
         start_op(s, dd, dv);
         wait_done(lat, bcnt, to);
         n_cmp++;
         if (to) begin
            n_bad++; $display("FAIL rnd%0d_timeout: no done within 40 clocks", k);
         end else if ({bus_if.quot, bus_if.rem, bus_if.v, bus_if.dz} !== {q, r, v, z} || lat != elat) begin
            n_bad++;
            $display("FAIL rnd%0d: s=%b %h/%h got q=%h r=%h v=%b dz=%b lat=%0d exp q=%h r=%h v=%b dz=%b lat=%0d",
                     k, s, dd, dv, bus_if.quot, bus_if.rem, bus_if.v, bus_if.dz, lat, q, r, v, z, elat);
         end
         prev_q = q;
      end
   endtask

   task automatic test_st_ignored;
      int  lat, i, extra;
      bit  to;
      @(negedge clk);
      start_op(1'b0, 8'h87, 4'hD);
      lat = 0; to = 1'b1; i = 0;
      while (to && i < 40) begin
         i++;
         @(posedge clk);
         #1;
         if (i == 2) begin
            n_cmp++; if (bus_if.quot !== prev_q) begin n_bad++; $display("FAIL hold_quot: got %h exp %h", bus_if.quot, prev_q); end
            bus_if.st = 1'b1; bus_if.dividend = 8'h14; bus_if.divisor = 4'h3;
         end
         if (i == 3) bus_if.st = 1'b0;
         if (bus_if.done === 1'b1) begin lat = i; to = 1'b0; end
      end
      n_cmp++;
      if (to) begin
         n_bad++; $display("FAIL ignore_timeout: no done within 40 clocks");
      end else if ({bus_if.quot, bus_if.rem, bus_if.v} !== {4'hA, 4'h5, 1'b0} || lat != 6) begin
         n_bad++;
         $display("FAIL ignore_result: got q=%h r=%h v=%b lat=%0d exp q=a r=5 v=0 lat=6", bus_if.quot, bus_if.rem, bus_if.v, lat);
      end
      extra = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (bus_if.busy === 1'b1 || bus_if.done === 1'b1) extra++;
      end
      n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL ignore_no_queue: got %0d active cycles exp 0", extra); end
      prev_q = 4'hA;
   endtask

   task automatic test_back_to_back;
      int lat, bcnt;
      bit to;
      @(negedge clk);
      start_op(1'b0, 8'h87, 4'hD);
      wait_done(lat, bcnt, to);
      n_cmp++; if (to || bus_if.quot !== 4'hA || bus_if.rem !== 4'h5) begin n_bad++; $display("FAIL b2b_first: got q=%h r=%h to=%b exp q=a r=5", bus_if.quot, bus_if.rem, to); end
      start_op(1'b0, 8'h14, 4'h3);
      wait_done(lat, bcnt, to);
      n_cmp++; if (to || lat != 6 || bus_if.quot !== 4'h6 || bus_if.rem !== 4'h2) begin n_bad++; $display("FAIL b2b_second: got q=%h r=%h lat=%0d exp q=6 r=2 lat=6", bus_if.quot, bus_if.rem, lat); end
      start_op(1'b1, 8'hCE, 4'h0);
      wait_done(lat, bcnt, to);
      n_cmp++; if (to || lat != 2 || bus_if.v !== 1'b1 || bus_if.dz !== 1'b1 || bus_if.quot !== 4'h0) begin n_bad++; $display("FAIL b2b_third: got v=%b dz=%b q=%h lat=%0d exp v=1 dz=1 q=0 lat=2", bus_if.v, bus_if.dz, bus_if.quot, lat); end
   endtask

   task automatic test_reset_mid;
      int lat, bcnt, dones;
      bit to;
      @(negedge clk);
      start_op(1'b0, 8'h87, 4'hD);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++; if (bus_if.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b exp 0", bus_if.busy); end
      n_cmp++; if (bus_if.v !== 1'b0 || bus_if.dz !== 1'b0) begin n_bad++; $display("FAIL rstmid_flags: got v=%b dz=%b exp 0 0", bus_if.v, bus_if.dz); end
      n_cmp++; if (bus_if.quot !== '0 || bus_if.rem !== '0) begin n_bad++; $display("FAIL rstmid_data: got q=%h r=%h exp 0 0", bus_if.quot, bus_if.rem); end
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (bus_if.done === 1'b1) dones++;
      end
      n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d done pulses exp 0", dones); end
      @(negedge clk);
      start_op(1'b1, 8'hCE, 4'h7);
      wait_done(lat, bcnt, to);
      n_cmp++; if (to || lat != 6 || bus_if.quot !== 4'h9 || bus_if.rem !== 4'hF) begin n_bad++; $display("FAIL rstmid_after: got q=%h r=%h lat=%0d exp q=9 r=f lat=6", bus_if.quot, bus_if.rem, lat); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_st_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
